quad_decode: RTL
================

QUAD_DECODE -- requirements
Module: quad_decode

Interface
REQ-001 Parameter FILT_LEN, default 3, is the number of consecutive identical synchronized samples needed to accept a new level; legal range 1..15.
REQ-002 Parameter MODE, default 4, selects the resolution: 1 = x1, 2 = x2, 4 = x4; other values are illegal and elaborate to an error.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 CD  input  1  asynchronous clear, active-high.
REQ-005 A  input  1  encoder phase A, asynchronous to CLK.
REQ-006 B  input  1  encoder phase B, asynchronous to CLK.
REQ-007 CS  input  1  synchronous clear, active-high: clears ERR, suppresses EN, re-arms initial load.
REQ-008 EN  output  1  count-enable pulse, one CLK wide, per counted transition; drives the downstream counter EN.
REQ-009 DNUP  output  1  direction of the last counted transition, 1 = down, 0 = up; drives the downstream counter DNUP.
REQ-010 ERR  output  1  sticky flag for an illegal transition (both phases changed together).

Function
REQ-011 Each phase shall pass a 2-flop synchronizer, then a saturating run-length filter.
REQ-012 The filtered level shall update at the edge where the synchronized level has differed from it for FILT_LEN consecutive samples; any mismatch break restarts the run.
REQ-013 Phase code is {A,B}; up sequence 00->10->11->01->00 (A leads B); down is the reverse.
REQ-014 Let a raw edge on A occur before edge n with setup met; the filtered level updates at edge n+1+FILT_LEN, and EN is high for the cycle after edge n+2+FILT_LEN.
REQ-015 MODE 4 shall count every legal single-bit transition.
REQ-016 MODE 2 shall count only transitions that change A (00<->10, 11<->01).
REQ-017 MODE 1 shall count only 00<->10.
REQ-018 DNUP shall be registered in the same cycle as a counted EN and hold its value between pulses.
REQ-019 A transition that changes both filtered bits in one cycle shall set ERR, produce no EN, and leave DNUP unchanged; the filtered code still takes the new value.
REQ-020 The first filtered code qualified after reset or CS shall load without EN or ERR (INIT state); normal decoding (RUN state) follows.
REQ-021 CS at the same edge as a legal or illegal transition: CS wins; EN = 0, ERR = 0, return to INIT.
REQ-022 At most one EN per filtered transition; with no filtered change, EN = 0.

Reset
REQ-023 CD high shall immediately force EN = 0, DNUP = 0, ERR = 0, synchronizers and filtered code = 00, run counters = 0, state = INIT.
REQ-024 CD deasserted mid-motion: decoding shall resume via INIT with no spurious EN or ERR.

Structure
REQ-025 Shared package quad_pkg shall hold the MODE encodings (X1, X2, X4), phase-code constants, and the INIT/RUN state type.
REQ-026 Sub-module quad_filt (synchronizer plus run-length filter, one phase) shall be instantiated twice.
REQ-027 Decode/direction/ERR logic lives in quad_decode; no combinational path from A/B to any output.

Verification
REQ-028 FILT_LEN=3, MODE=4, after INIT: step AB 00->10 held 10 cycles -> EN high for exactly one cycle, 5 edges after the change; DNUP = 0.
REQ-029 MODE=4: full down cycle 00->01->11->10->00, 20 cycles per step -> 4 EN pulses, DNUP = 1 at each.
REQ-030 FILT_LEN=3: 2-cycle glitch on A -> no EN and filtered code unchanged; 3-cycle level -> one EN.
REQ-031 Jump 00->11 in one step -> ERR = 1, no EN, ERR stays 1 until CS; CS pulse -> ERR = 0 and the next qualified code loads silently.
REQ-032 MODE=1, full up cycle -> exactly 1 EN (at 00->10); MODE=2 -> exactly 2 EN.
REQ-033 Assert CD with A=B=1 held, then release -> EN/ERR = 0 throughout; the subsequent 11->01 step produces one up EN.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg
// Shared definitions for the quadrature decoder: resolution mode codes,
// phase-code constants ({A,B}), decoder state type and a helper that
// classifies the step between two phase codes.
package quad_pkg;

    // Resolution selections for the MODE parameter
    localparam int X1 = 1;
    localparam int X2 = 2;
    localparam int X4 = 4;

    // Phase codes {A,B}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00
    localparam logic [1:0] CODE_00 = 2'b00;
    localparam logic [1:0] CODE_10 = 2'b10;
    localparam logic [1:0] CODE_11 = 2'b11;
    localparam logic [1:0] CODE_01 = 2'b01;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_ILLEGAL
    } step_t;

    // Position of a phase code along the up sequence (Gray to binary).
    function automatic logic [1:0] code_pos(input logic [1:0] code);
        return {code[0], code[1] ^ code[0]};
    endfunction

    // A position difference of +1 is up, -1 is down, 2 means both phases moved.
    function automatic step_t classify(input logic [1:0] prev, input logic [1:0] curr);
        logic [1:0] delta;
        delta = code_pos(curr) - code_pos(prev);
        case (delta)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_UP;
            2'd3:    return STEP_DOWN;
            default: return STEP_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/quad_decode_if.sv
// quad_decode_if
// Encoder-side and counter-side signals of the quadrature decoder.
//   A, B  : encoder phases (asynchronous to the decoder clock)
//   CS    : synchronous clear
//   EN    : one-cycle count-enable pulse per counted transition
//   DNUP  : direction of the last counted transition (1 = down)
//   ERR   : sticky illegal-transition flag
interface quad_decode_if;
    logic A;
    logic B;
    logic CS;
    logic EN;
    logic DNUP;
    logic ERR;

    modport master (
        output A, B, CS,
        input  EN, DNUP, ERR
    );

    modport slave (
        input  A, B, CS,
        output EN, DNUP, ERR
    );
endinterface

// File: rtl/quad_filt.sv
// quad_filt
// One encoder phase: 2-flop synchronizer followed by a run-length filter.
// The filtered level only follows the synchronized level once the two have
// disagreed for FILT_LEN consecutive samples; any agreement restarts the run.
//   clk     : clock
//   rst     : asynchronous clear, active-high
//   raw_i   : raw phase input, asynchronous to clk
//   level_o : filtered (registered) phase level
module quad_filt #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);

    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("quad_filt: FILT_LEN must be in 1..15");
    end

    localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       level_d;
    logic [3:0] run_q;
    logic [3:0] run_d;

    // The run counter never exceeds RUN_LAST: reaching it accepts the new
    // level and restarts from zero.
    always_comb begin
        level_d = level_q;
        run_d   = 4'd0;
        if (sync2_q != level_q) begin
            if (run_q == RUN_LAST) begin
                level_d = sync2_q;
            end else begin
                run_d = run_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            run_q   <= 4'd0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            run_q   <= run_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/quad_decode.sv
// quad_decode
// Quadrature decoder: filters both encoder phases, decodes direction and
// produces count-enable pulses at x1/x2/x4 resolution, flags illegal jumps.
//   CLK : clock
//   CD  : asynchronous clear, active-high
//   bus : quad_decode_if slave (A, B, CS in; EN, DNUP, ERR out)
module quad_decode
    import quad_pkg::*;
#(
    parameter int FILT_LEN = 3,
    parameter int MODE     = 4
) (
    input  logic          CLK,
    input  logic          CD,
    quad_decode_if.slave  bus
);

    if (MODE != X1 && MODE != X2 && MODE != X4) begin : g_bad_mode
        $error("quad_decode: MODE must be 1, 2 or 4");
    end

    // INIT lasts long enough for a level present at reset release to pass the
    // synchronizer and filter, so it is absorbed rather than decoded.
    localparam logic [4:0] INIT_LAST = 5'(FILT_LEN + 2);

    logic       filt_a;
    logic       filt_b;
    logic [1:0] code_now;

    quad_filt #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk     (CLK),
        .rst     (CD),
        .raw_i   (bus.A),
        .level_o (filt_a)
    );

    quad_filt #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk     (CLK),
        .rst     (CD),
        .raw_i   (bus.B),
        .level_o (filt_b)
    );

    assign code_now = {filt_a, filt_b};

    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [4:0] init_cnt_q, init_cnt_d;
    logic       en_q, en_d;
    logic       dnup_q, dnup_d;
    logic       err_q, err_d;
    step_t      step;
    logic       counted;

    // Resolution gating: x2 counts only A edges, x1 only the 00<->10 pair.
    always_comb begin
        counted = 1'b0;
        if (MODE == X4) begin
            counted = 1'b1;
        end else if (MODE == X2) begin
            counted = (code_q[1] != code_now[1]);
        end else begin
            counted = (code_q[0] == 1'b0) && (code_now[0] == 1'b0) &&
                      (code_q[1] != code_now[1]);
        end
    end

    // The filtered code is always tracked; only RUN turns changes into EN/ERR.
    always_comb begin
        step       = classify(code_q, code_now);
        state_d    = state_q;
        code_d     = code_now;
        init_cnt_d = init_cnt_q;
        en_d       = 1'b0;
        dnup_d     = dnup_q;
        err_d      = err_q;
        if (bus.CS) begin
            state_d    = ST_INIT;
            init_cnt_d = 5'd0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        init_cnt_d = init_cnt_q + 5'd1;
                    end
                end
                ST_RUN: begin
                    if (step == STEP_ILLEGAL) begin
                        err_d = 1'b1;
                    end else if ((step == STEP_UP || step == STEP_DOWN) && counted) begin
                        en_d   = 1'b1;
                        dnup_d = (step == STEP_DOWN);
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CD) begin
        if (CD) begin
            state_q    <= ST_INIT;
            code_q     <= CODE_00;
            init_cnt_q <= 5'd0;
            en_q       <= 1'b0;
            dnup_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            init_cnt_q <= init_cnt_d;
            en_q       <= en_d;
            dnup_q     <= dnup_d;
            err_q      <= err_d;
        end
    end

    assign bus.EN   = en_q;
    assign bus.DNUP = dnup_q;
    assign bus.ERR  = err_q;

endmodule
